// File: rtl/aes_128_mc_top_if.sv
// rtl/aes_128_mc_top_if.sv - plaintext-in / ciphertext-out stream bundle for aes_128_mc_top
interface aes_128_mc_top_if #(
  parameter int CH_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [127:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [127:0]    out_data;

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/aes_128_mc_top.sv
// rtl/aes_128_mc_top.sv - multi-channel iterative AES-128 encryptor; optional output FIFO via AES_128_OUT_FIFO_EN
module aes_128_mc_top #(
  parameter  int NUM_CH    = 4,
  parameter  int OUT_DEPTH = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              kill_n,
  input  logic              key_wr_en,
  input  logic [CH_W-1:0]   key_wr_ch,
  input  logic [127:0]      key_wr_data,
  aes_128_mc_top_if.slave   bus,
  output logic              idle,
  output logic              ch_err_irq_pulse
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          fsm_q, fsm_d;
  logic [127:0]    key_q [NUM_CH];
  logic [127:0]    state_q, rkey_q, sel_key;
  logic [3:0]      rnd_q;
  logic [CH_W-1:0] ch_q;
  logic            in_legal, kch_legal, accept, done, full, in_rdy, err_q;
  logic [127:0]    sr_bytes, mc_bytes, round_out;
  logic [31:0]     key_t, nk0, nk1, nk2, nk3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign in_legal  = 32'(bus.in_ch) < 32'(NUM_CH);
  assign kch_legal = 32'(key_wr_ch) < 32'(NUM_CH);
  assign accept    = bus.in_valid && in_rdy;
  assign done      = (fsm_q == S_RUN) && (rnd_q == 4'd10);
  assign bus.in_ready     = in_rdy;
  assign ch_err_irq_pulse = err_q;
  assign idle             = (fsm_q == S_IDLE) && !bus.out_valid;

  // key file read mux; out-of-range channels read as zero and are never used
  always_comb begin
    sel_key = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.in_ch == CH_W'(i)) sel_key = key_q[i];
  end

  // one AES round: next round key, SubBytes+ShiftRows, MixColumns (bypassed in round 10), AddRoundKey
  always_comb begin
    key_t = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]), sbox(rkey_q[7:0]), sbox(rkey_q[31:24])}
            ^ {rcon(rnd_q), 24'h0};
    nk0 = rkey_q[127:96] ^ key_t;
    nk1 = rkey_q[95:64]  ^ nk0;
    nk2 = rkey_q[63:32]  ^ nk1;
    nk3 = rkey_q[31:0]   ^ nk2;
    sr_bytes = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr_bytes[8*(15-(r+4*c)) +: 8] = sbox(state_q[8*(15-(r+4*((c+r)%4))) +: 8]);
    mc_bytes = '0;
    for (int c = 0; c < 4; c++)
      mc_bytes[32*(3-c) +: 32] = mix_col(sr_bytes[32*(3-c) +: 32]);
    round_out = ((rnd_q == 4'd10) ? sr_bytes : mc_bytes) ^ {nk0, nk1, nk2, nk3};
  end

  // key file: writes to illegal channels match no register and are dropped
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      for (int i = 0; i < NUM_CH; i++) key_q[i] <= '0;
    end else if (key_wr_en) begin
      for (int i = 0; i < NUM_CH; i++)
        if (key_wr_ch == CH_W'(i)) key_q[i] <= key_wr_data;
    end
  end

  // engine state register
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) fsm_q <= S_IDLE;
    else         fsm_q <= fsm_d;
  end

  // engine next state and in_ready (depends on state and full only)
  always_comb begin
    fsm_d  = fsm_q;
    in_rdy = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        in_rdy = !full;
        if (bus.in_valid && !full && in_legal) fsm_d = S_RUN;
      end
      S_RUN: begin
        if (rnd_q == 4'd10) fsm_d = S_IDLE;
      end
    endcase
  end

  // datapath: initial AddRoundKey on accept, then one round per cycle
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
      ch_q    <= '0;
    end else if (accept && in_legal) begin
      state_q <= bus.in_data ^ sel_key;
      rkey_q  <= sel_key;
      rnd_q   <= 4'd1;
      ch_q    <= bus.in_ch;
    end else if (fsm_q == S_RUN) begin
      state_q <= round_out;
      rkey_q  <= {nk0, nk1, nk2, nk3};
      rnd_q   <= rnd_q + 4'd1;
    end
  end

  // error pulse: an illegal key write and an illegal block in the same cycle give one pulse
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) err_q <= 1'b0;
    else         err_q <= (key_wr_en && !kch_legal) || (accept && !in_legal);
  end

`ifdef AES_128_OUT_FIFO_EN
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [127:0]    fifo_data [OUT_DEPTH];
  logic [CH_W-1:0] fifo_ch   [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop;

  assign full          = (count == (PTR_W+1)'(OUT_DEPTH));
  assign pop           = (count != '0) && bus.out_ready;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_ch    = fifo_ch[rd_ptr];

  // show-ahead output FIFO; the engine never writes while full since accepts stop at full
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_ch[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (done) begin
        fifo_data[wr_ptr] <= round_out;
        fifo_ch[wr_ptr]   <= ch_q;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (done && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!done && pop) count <= count - (PTR_W+1)'(1);
    end
  end
`else
  logic            ov_q;
  logic [127:0]    od_q;
  logic [CH_W-1:0] oc_q;
  logic            unused_out_ready;

  assign unused_out_ready = bus.out_ready;
  assign full             = 1'b0;
  assign bus.out_valid    = ov_q;
  assign bus.out_data     = od_q;
  assign bus.out_ch       = oc_q;

  // single output register: valid pulses for one cycle, data held until the next block
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
      oc_q <= '0;
    end else begin
      ov_q <= done;
      if (done) begin
        od_q <= round_out;
        oc_q <= ch_q;
      end
    end
  end
`endif

endmodule
